muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_iter.sv | 63 ++++++
 rtl/muldiv_unit.sv | 138 +++++++++++++
 tb/tb_muldiv_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The op codes follow the two-bit op port: bit 1 selects divide, bit 0 selects unsigned.
package muldiv_pkg;
  localparam int ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_e;
endpackage

// File: rtl/muldiv_iter.sv
// Iterative datapath: a 64-bit accumulator doing one shift-add or restoring shift-subtract step
// per i_step, with a down-counter that flags the final step.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int ITER = muldiv_pkg::ITER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_step,
  input  logic        i_div,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_acc,
  output logic        o_last
);
  localparam int CW = $clog2(ITER + 1);

  logic [63:0]   r_acc;
  logic [31:0]   r_opnd;
  logic [CW-1:0] r_cnt;
  logic          r_div;

  logic [32:0] w_sum;
  logic [32:0] w_diff;
  logic [63:0] w_acc_nxt;

  // Layout: upper half is the partial product / remainder, lower half shifts out the
  // multiplier or dividend while quotient bits shift in.
  always_comb begin
    w_sum  = {1'b0, r_acc[63:32]} + {1'b0, r_opnd};
    w_diff = r_acc[63:31] - {1'b0, r_opnd};
    if (r_div) begin
      if (!w_diff[32]) w_acc_nxt = {w_diff[31:0], r_acc[30:0], 1'b1};
      else             w_acc_nxt = {r_acc[62:0], 1'b0};
    end else if (r_acc[0]) begin
      w_acc_nxt = {w_sum, r_acc[31:1]};
    end else begin
      w_acc_nxt = {1'b0, r_acc[63:1]};
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      r_acc  <= '0;
      r_opnd <= '0;
      r_cnt  <= '0;
      r_div  <= 1'b0;
    end else if (i_load) begin
      r_acc  <= {32'd0, i_a};
      r_opnd <= i_b;
      r_cnt  <= CW'(ITER);
      r_div  <= i_div;
    end else if (i_step) begin
      r_acc  <= w_acc_nxt;
      r_cnt  <= r_cnt - 1'b1;
    end
  end

  assign o_acc  = r_acc;
  assign o_last = (r_cnt == CW'(1));
endmodule

// File: rtl/muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit: sequencing FSM, operand sign handling and HI/LO registers.
// State | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// CALC  | one datapath step per cycle, ITER cycles
// SIGN  | sign correction of product or quotient/remainder
// DONE  | result loaded into hi/lo on the exit edge, done pulses
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int ITER = muldiv_pkg::ITER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);
  state_e      r_state;
  state_e      w_state_nxt;
  op_e         r_op;
  logic        r_sign_a;
  logic        r_sign_b;
  logic        r_b_zero;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;
  logic [63:0] r_res;

  logic        w_signed;
  logic        w_load;
  logic        w_step;
  logic        w_last;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [63:0] w_acc;
  logic [63:0] w_fixed;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_signed = ~op[0];
  assign w_a_mag  = (w_signed && a[31]) ? -a : a;
  assign w_b_mag  = (w_signed && b[31]) ? -b : b;

  muldiv_iter #(.ITER(ITER)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_step (w_step),
    .i_div  (op[1]),
    .i_a    (w_a_mag),
    .i_b    (w_b_mag),
    .o_acc  (w_acc),
    .o_last (w_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !flush) begin
          w_load      = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (w_last) w_state_nxt = S_SIGN;
        end
      end
      S_SIGN:  w_state_nxt = flush ? S_IDLE : S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Divide by zero keeps the all-ones quotient unsigned; the remainder sign rule alone restores hi=a.
  always_comb begin
    w_quot = w_acc[31:0];
    w_rem  = w_acc[63:32];
    if ((r_sign_a ^ r_sign_b) && !r_b_zero) w_quot = -w_acc[31:0];
    if (r_sign_a) w_rem = -w_acc[63:32];
    if (r_op == OP_DIV || r_op == OP_DIVU) w_fixed = {w_rem, w_quot};
    else                                   w_fixed = (r_sign_a ^ r_sign_b) ? -w_acc : w_acc;
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= OP_MULT;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_b_zero <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_res    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (w_load) begin
        r_op     <= op_e'(op);
        r_sign_a <= w_signed & a[31];
        r_sign_b <= w_signed & b[31];
        r_b_zero <= (b == 32'd0);
      end
      if (r_state == S_SIGN) r_res <= w_fixed;
      if (r_state == S_IDLE) begin
        if (wr_hi) r_hi <= wdata;
        if (wr_lo) r_lo <= wdata;
      end
      if (r_state == S_DONE && !flush) begin
        {r_hi, r_lo} <= r_res;
        r_done       <= 1'b1;
      end
    end
  end

  assign hi    = r_hi;
  assign lo    = r_lo;
  assign done  = r_done;
  assign busy  = (r_state == S_CALC) || (r_state == S_SIGN);
  assign stall = busy || (start && r_state == S_IDLE);
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops against an arithmetic model.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, start, flush, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_unit #(.ITER(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected {hi, lo} straight from integer arithmetic.
  function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'd0: begin q = sx * sy; p = q; return p; end
      2'd1: return ux * uy;
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (o == 2'd2) begin
          q = sx / sy;
          r = sx % sy;
          return {r[31:0], q[31:0]};
        end
        p = ux % uy;
        q = longint'(ux / uy);
        return {p[31:0], q[31:0]};
      end
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic watch_no_done(input string tag, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done) cnt++;
    end
    chk(tag, cnt, 0);
  endtask

  task automatic mt(input bit to_hi, input logic [31:0] d);
    wr_hi = to_hi; wr_lo = ~to_hi; wdata = d;
    tick();
    wr_hi = 0; wr_lo = 0;
    if (to_hi) m_hi = d; else m_lo = d;
    chk(to_hi ? "mthi" : "mtlo", to_hi ? hi : lo, d);
  endtask

  // Runs one op from IDLE; keep_start hammers start/wr_* with junk while the op is running.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input bit keep_start);
    logic [63:0] exp;
    int n_busy, n_stall, lat;
    exp = ref_op(o, x, y);
    start = 1; op = o; a = x; b = y;
    #1;
    n_stall = stall ? 1 : 0;
    n_busy  = 0;
    lat     = -1;
    for (int e = 0; e < 60; e++) begin
      @(negedge clk);
      #1;
      if (keep_start && e < 33) begin
        start = 1; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
        wr_hi = 1; wr_lo = 1; wdata = $urandom;
      end else begin
        start = 0; wr_hi = 0; wr_lo = 0;
      end
      #1;
      if (busy)  n_busy++;
      if (stall) n_stall++;
      if (done) begin
        lat = e;
        break;
      end
    end
    chk({tag, "_latency"}, lat, 34);
    chk({tag, "_busy_cycles"}, n_busy, 33);
    chk({tag, "_stall_cycles"}, n_stall, 34);
    chk({tag, "_hilo"}, {hi, lo}, exp);
    {m_hi, m_lo} = exp;
    tick();
    chk({tag, "_done_drop"}, done, 0);
  endtask

  initial begin
    reset = 1; start = 0; flush = 0; wr_hi = 0; wr_lo = 0;
    op = 0; a = 0; b = 0; wdata = 0;
    m_hi = 0; m_lo = 0;
    tick(); tick();
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_flags", {busy, done, stall}, 3'b000);
    reset = 0;
    tick();

    do_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op("mult_neg", 2'd0, -32'sd3, 32'd5, 1'b0);
    do_op("div_neg", 2'd2, -32'sd7, 32'd2, 1'b0);
    do_op("divu_zero", 2'd3, 32'd7, 32'd0, 1'b0);
    do_op("div_zero_neg", 2'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
    do_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op("ignore_start", 2'd0, 32'h1234_5678, 32'h8765_4321, 1'b1);

    // Flush in cycle 10 of a DIVU.
    mt(1'b1, 32'h1234_5678);
    mt(1'b0, 32'h0BAD_F00D);
    start = 1; op = 2'd3; a = 32'd100; b = 32'd7;
    tick();
    start = 0;
    repeat (9) tick();
    flush = 1;
    tick();
    flush = 0;
    chk("flush_idle", busy, 0);
    chk("flush_hilo", {hi, lo}, {m_hi, m_lo});
    watch_no_done("flush_nodone", 40);
    do_op("divu_retry", 2'd3, 32'd100, 32'd7, 1'b0);

    // Reset in cycle 20 of a MULT.
    start = 1; op = 2'd0; a = 32'd12345; b = -32'sd678;
    tick();
    start = 0;
    repeat (19) tick();
    reset = 1;
    tick();
    reset = 0;
    m_hi = 0; m_lo = 0;
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    chk("rst_mid_busy", busy, 0);
    watch_no_done("rst_mid_nodone", 40);

    // start and flush together in IDLE.
    start = 1; flush = 1; op = 2'd1; a = 32'd9; b = 32'd9;
    tick();
    start = 0; flush = 0;
    #1;
    chk("start_flush_idle", {busy, stall}, 2'b00);
    watch_no_done("start_flush_nodone", 40);
    chk("start_flush_hilo", {hi, lo}, {m_hi, m_lo});

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op("rand", ro, ra, rb, i[2]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
